mdu_iter: RTL and testbench

Multi-cycle multiply/divide unit for the CPU execute stage, the sequential counterpart to the single-cycle combinational ALU. The control logic issues one mult/multu/div/divu operation with a start strobe. The unit holds Busy while it computes and commits the result to internal HI/LO registers, which are readable at all times. Moves into HI/LO (mthi/mtlo) complete in a single cycle. The pipeline stalls on Busy, or on Start, before any HI/LO access.

---
 rtl/mdu_iter_if.sv | 14 +
 rtl/mdu_iter.sv | 146 ++++++++++++++
 tb/tb_mdu_iter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
// Issue/result bundle between the execute-stage control and the multi-cycle
// multiply/divide unit.
interface mdu_iter_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output A, B, MDUOp, Start, input Busy, HI, LO);
  modport slave  (input A, B, MDUOp, Start, output Busy, HI, LO);
endinterface

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit: latches the full result at issue, holds
// Busy for a fixed latency, then commits the result into the HI/LO registers.
//
// state  | meaning
// S_IDLE | no operation in flight; accepts issue, mthi and mtlo
// S_RUN  | counting down the latency; result commits when cnt hits 1
module mdu_iter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_iter_if.slave bus
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_commit;
  logic        r_busy;
  logic        r_div_zero;
  logic [31:0] r_rhi;
  logic [31:0] r_rlo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_op_mul;
  logic        w_op_div;
  logic        w_issue;
  logic        w_a_neg;
  logic        w_b_neg;
  logic        w_b_zero;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [63:0] w_prod;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_op_mul = (bus.MDUOp == OP_MULT) || (bus.MDUOp == OP_MULTU);
  assign w_op_div = (bus.MDUOp == OP_DIV)  || (bus.MDUOp == OP_DIVU);
  assign w_issue  = (r_state == S_IDLE) && bus.Start && (w_op_mul || w_op_div);

  // Sign-extended operands: the low 64 bits of the product are the signed product.
  assign w_prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
  assign w_prod_u = {32'd0, bus.A} * {32'd0, bus.B};
  assign w_prod   = (bus.MDUOp == OP_MULT) ? w_prod_s : w_prod_u;

  // Signed divide works on magnitudes; 0x80000000 / -1 falls out as 0x80000000 r 0.
  assign w_a_neg  = (bus.MDUOp == OP_DIV) && bus.A[31];
  assign w_b_neg  = (bus.MDUOp == OP_DIV) && bus.B[31];
  assign w_a_mag  = w_a_neg ? (~bus.A + 32'd1) : bus.A;
  assign w_b_mag  = w_b_neg ? (~bus.B + 32'd1) : bus.B;
  assign w_b_zero = (bus.B == 32'd0);
  assign w_b_safe = w_b_zero ? 32'd1 : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_safe;
  assign w_r_mag  = w_a_mag % w_b_safe;
  assign w_quot   = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_rem    = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  assign w_res_hi = w_op_mul ? w_prod[63:32] : w_rem;
  assign w_res_lo = w_op_mul ? w_prod[31:0]  : w_quot;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = w_op_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
        end
      end
      S_RUN: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rhi      <= 32'd0;
      r_rlo      <= 32'd0;
      r_div_zero <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
    end else begin
      if (w_issue) begin
        r_rhi      <= w_res_hi;
        r_rlo      <= w_res_lo;
        r_div_zero <= w_op_div && w_b_zero;
      end
      // Divide by zero still burns the full latency but leaves HI/LO alone.
      if (w_commit && !r_div_zero) begin
        r_hi <= r_rhi;
        r_lo <= r_rlo;
      end
      if (r_state == S_IDLE && bus.MDUOp == OP_MTHI) r_hi <= bus.A;
      if (r_state == S_IDLE && bus.MDUOp == OP_MTLO) r_lo <= bus.A;
    end
  end

  assign bus.Busy = r_busy;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases followed by random
// operations checked against an arithmetic reference model.
module tb_mdu_iter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_iter_if bus();

  mdu_iter dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: updates m_hi/m_lo from the arithmetic definition.
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          q;
    longint          r;
    logic     [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd3: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      default: ;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op);
    return (op == 3'd1 || op == 3'd2) ? 5 : 10;
  endfunction

  // Called at a falling edge; returns at the falling edge after the commit edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          n;
    old_hi = m_hi;
    old_lo = m_lo;
    n = latency(op);
    ref_op(op, a, b);
    bus.A = a; bus.B = b; bus.MDUOp = op; bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0; bus.MDUOp = 3'd0; bus.A = $urandom; bus.B = $urandom;
    for (int i = 1; i <= n; i++) begin
      check("busy_run", 32'(bus.Busy), 32'd1);
      check("hi_hold", bus.HI, old_hi);
      check("lo_hold", bus.LO, old_lo);
      if (inject && i == 1) begin
        bus.Start = 1'b1; bus.MDUOp = 3'd1; bus.A = 32'd99; bus.B = 32'd99;
      end else if (inject && i == 2) begin
        bus.Start = 1'b0; bus.MDUOp = 3'd6; bus.A = 32'hDEADBEEF;
      end else if (inject && i == 3) begin
        bus.MDUOp = 3'd0;
      end
      @(negedge clk);
    end
    check("busy_done", 32'(bus.Busy), 32'd0);
    check("hi_result", bus.HI, m_hi);
    check("lo_result", bus.LO, m_lo);
  endtask

  task automatic do_move(input logic [2:0] op, input logic [31:0] a);
    bus.MDUOp = op; bus.A = a; bus.Start = ($urandom_range(0, 1) == 1);
    if (op == 3'd5) m_hi = a; else m_lo = a;
    @(negedge clk);
    bus.MDUOp = 3'd0; bus.Start = 1'b0;
    check("move_busy", 32'(bus.Busy), 32'd0);
    check("move_hi", bus.HI, m_hi);
    check("move_lo", bus.LO, m_lo);
  endtask

  task automatic do_noop(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic start);
    bus.MDUOp = op; bus.A = a; bus.B = b; bus.Start = start;
    @(negedge clk);
    bus.MDUOp = 3'd0; bus.Start = 1'b0;
    check("noop_busy", 32'(bus.Busy), 32'd0);
    check("noop_hi", bus.HI, m_hi);
    check("noop_lo", bus.LO, m_lo);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    checks = 0;
    errors = 0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    reset = 1'b1;
    bus.A = 32'd0; bus.B = 32'd0; bus.MDUOp = 3'd0; bus.Start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("multu_hi", bus.HI, 32'hFFFFFFFE);
    check("multu_lo", bus.LO, 32'h00000001);

    run_op(3'd1, 32'hFFFFFFFD, 32'h00000007, 1'b0);
    check("mult_hi", bus.HI, 32'hFFFFFFFF);
    check("mult_lo", bus.LO, 32'hFFFFFFEB);

    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_hi", bus.HI, 32'hFFFFFFFF);
    check("div_lo", bus.LO, 32'hFFFFFFFD);

    run_op(3'd4, 32'd100, 32'd7, 1'b0);
    check("divu_hi", bus.HI, 32'd2);
    check("divu_lo", bus.LO, 32'd14);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("divovf_hi", bus.HI, 32'd0);
    check("divovf_lo", bus.LO, 32'h80000000);

    do_move(3'd5, 32'h12345678);
    do_move(3'd6, 32'h9ABCDEF0);
    check("mthi_val", bus.HI, 32'h12345678);
    check("mtlo_val", bus.LO, 32'h9ABCDEF0);
    run_op(3'd4, 32'd55, 32'd0, 1'b0);
    check("dz_hi", bus.HI, 32'h12345678);
    check("dz_lo", bus.LO, 32'h9ABCDEF0);

    // Reset during the third RUN cycle discards the pending product.
    bus.A = 32'd3; bus.B = 32'd4; bus.MDUOp = 3'd1; bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0; bus.MDUOp = 3'd0;
    check("abort_busy1", 32'(bus.Busy), 32'd1);
    @(negedge clk);
    check("abort_busy2", 32'(bus.Busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_hi", bus.HI, 32'd0);
    check("abort_lo", bus.LO, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("late_busy", 32'(bus.Busy), 32'd0);
      check("late_hi", bus.HI, 32'd0);
      check("late_lo", bus.LO, 32'd0);
    end

    run_op(3'd1, 32'd3, 32'd4, 1'b1);
    check("inj_hi", bus.HI, 32'd0);
    check("inj_lo", bus.LO, 32'd12);

    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      if (op >= 3'd1 && op <= 3'd4) begin
        if ($urandom_range(0, 3) == 0) do_noop(op, a, b, 1'b0);
        else run_op(op, a, b, $urandom_range(0, 3) == 0);
      end else if (op == 3'd5 || op == 3'd6) begin
        do_move(op, a);
      end else begin
        do_noop(op, a, b, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
